split: RTL and testbench

//  Address-decoding 1-to-N demux for the native valid/ready bus. It sits directly

---
 rtl/split.sv | 140 ++++++++++++++
 tb/tb_split.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/split.sv
// Address-decoding 1-to-N demux for the valid/ready bus: routes one request stream
// to a slave chosen by the top address bits, returns its response, times out silent slaves.
module split #(
  parameter int                N_SLAVES = 2,
  parameter int                DATA_W   = 32,
  parameter int                ADDR_W   = 32,
  parameter int                TIMEOUT  = 256,
  parameter logic [DATA_W-1:0] ERR_DATA = 32'hDEADBEEF
) (
  input  logic                                              clk,
  input  logic                                              rst,
  input  logic [ADDR_W+DATA_W+DATA_W/8:0]                   m_req,
  output logic [DATA_W:0]                                   m_resp,
  output logic [N_SLAVES*(1+ADDR_W+DATA_W+DATA_W/8)-1:0]   s_req,
  input  logic [N_SLAVES*(DATA_W+1)-1:0]                    s_resp,
  output logic                                              err_o,
  input  logic                                              err_clr
);
  localparam int REQ_W  = 1 + ADDR_W + DATA_W + DATA_W/8;
  localparam int RESP_W = DATA_W + 1;
  localparam int NB     = (N_SLAVES > 1) ? $clog2(N_SLAVES) : 1;
  localparam int CNT_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [1:0] {IDLE, BUSY, ERR} state_t;

  state_t            state_q, state_d;
  logic [NB-1:0]     sel_q, sel_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              err_q;

  logic              m_valid;
  logic [ADDR_W-1:0] addr;
  logic [NB-1:0]     idx, tgt;
  logic              idx_ok;
  logic [RESP_W-1:0] rsp_sel;
  logic              sel_rdy;
  logic              route_en, resp_slv, resp_err, err_set;

  assign m_valid = m_req[REQ_W-1];
  assign addr    = m_req[REQ_W-2 -: ADDR_W];

  if (N_SLAVES == 1) begin : g_one
    assign idx = '0;
  end else begin : g_many
    assign idx = addr[ADDR_W-1 -: NB];
  end

  assign idx_ok = (32'(idx) < 32'(N_SLAVES));
  // In BUSY the latched index steers both directions; otherwise the live decode does.
  assign tgt    = (state_q == BUSY) ? sel_q : idx;

  always_comb begin
    rsp_sel = '0;
    for (int k = 0; k < N_SLAVES; k++)
      if (32'(k) == 32'(tgt)) rsp_sel = s_resp[k*RESP_W +: RESP_W];
  end
  assign sel_rdy = rsp_sel[0];

  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    cnt_d    = cnt_q;
    route_en = 1'b0;
    resp_slv = 1'b0;
    resp_err = 1'b0;
    err_set  = 1'b0;
    case (state_q)
      IDLE: begin
        if (m_valid) begin
          if (idx_ok) begin
            route_en = 1'b1;
            resp_slv = 1'b1;
            if (!sel_rdy) begin
              state_d = BUSY;
              sel_d   = idx;
              cnt_d   = '0;
            end
          end else begin
            state_d = ERR;
          end
        end
      end
      BUSY: begin
        if (TIMEOUT > 0) cnt_d = cnt_q + CNT_W'(1);
        // A ready arriving on the timeout cycle still completes normally.
        if (sel_rdy) begin
          route_en = 1'b1;
          resp_slv = 1'b1;
          state_d  = IDLE;
        end else if (TIMEOUT > 0 && cnt_q == TO_LAST) begin
          resp_err = 1'b1;
          err_set  = 1'b1;
          state_d  = IDLE;
        end else begin
          route_en = 1'b1;
          resp_slv = 1'b1;
        end
      end
      ERR: begin
        resp_err = 1'b1;
        err_set  = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are gated by rst so an abandoned request disappears immediately.
  always_comb begin
    s_req = '0;
    for (int k = 0; k < N_SLAVES; k++)
      if (route_en && !rst && 32'(k) == 32'(tgt)) s_req[k*REQ_W +: REQ_W] = m_req;
  end

  always_comb begin
    m_resp = '0;
    if (!rst) begin
      if (resp_err)      m_resp = {ERR_DATA, 1'b1};
      else if (resp_slv) m_resp = rsp_sel;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      sel_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
      if (err_set)      err_q <= 1'b1;
      else if (err_clr) err_q <= 1'b0;
    end
  end

  assign err_o = err_q;
endmodule

// File: tb/tb_split.sv
// Directed bench for split: a 4-slave instance and a 3-slave instance (decode errors),
// both with an 8-cycle timeout.
module tb_split;
  localparam int REQ_W  = 69;
  localparam int RESP_W = 33;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [REQ_W-1:0]    a_mreq, b_mreq;
  logic [RESP_W-1:0]   a_mresp, b_mresp;
  logic [4*REQ_W-1:0]  a_sreq;
  logic [4*RESP_W-1:0] a_sresp;
  logic [3*REQ_W-1:0]  b_sreq;
  logic [3*RESP_W-1:0] b_sresp;
  logic a_err, b_err, a_clr, b_clr;
  int total = 0;
  int bad   = 0;

  logic [REQ_W-1:0] r1, r2, r5a, r5b, r4, r7, rb, r6;

  always #5 clk = ~clk;

  split #(.N_SLAVES(4), .DATA_W(32), .ADDR_W(32), .TIMEOUT(8), .ERR_DATA(32'hDEADBEEF)) u_a (
    .clk(clk), .rst(rst), .m_req(a_mreq), .m_resp(a_mresp), .s_req(a_sreq),
    .s_resp(a_sresp), .err_o(a_err), .err_clr(a_clr));

  split #(.N_SLAVES(3), .DATA_W(32), .ADDR_W(32), .TIMEOUT(8), .ERR_DATA(32'hDEADBEEF)) u_b (
    .clk(clk), .rst(rst), .m_req(b_mreq), .m_resp(b_mresp), .s_req(b_sreq),
    .s_resp(b_sresp), .err_o(b_err), .err_clr(b_clr));

  task automatic chk(input string tag, input logic [287:0] got, input logic [287:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [REQ_W-1:0] rq(input logic [31:0] addr, input logic [31:0] wd);
    return {1'b1, addr, wd, 4'hF};
  endfunction

  function automatic logic [287:0] at(input int k, input logic [REQ_W-1:0] r);
    logic [287:0] v;
    v = '0;
    v[k*REQ_W +: REQ_W] = r;
    return v;
  endfunction

  function automatic logic [287:0] rsp(input logic [31:0] d);
    return 288'({d, 1'b1});
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic a_set(input int k, input logic [31:0] d, input logic r);
    a_sresp[k*RESP_W +: RESP_W] = {d, r};
  endtask

  initial begin
    a_mreq = '0; b_mreq = '0; a_sresp = '0; b_sresp = '0;
    a_clr = 1'b0; b_clr = 1'b0;
    tick;
    // reset state, including a valid request held during reset
    chk("rst_mresp", 288'(a_mresp), '0);
    chk("rst_err", 288'(a_err), '0);
    chk("rst_berr", 288'(b_err), '0);
    a_mreq = rq(32'h4000_0010, 32'h1);
    #1 chk("rst_sreq_gated", 288'(a_sreq), '0);
    a_mreq = '0;
    tick;
    rst = 1'b0;
    tick;

    // 1: slave1, ready on cycle 3
    r1 = rq(32'h4000_0010, 32'hCAFE_0001);
    a_mreq = r1;
    #1 chk("t1_sreq_c0", 288'(a_sreq), at(1, r1));
    chk("t1_resp_c0", 288'(a_mresp), '0);
    tick; chk("t1_resp_c1", 288'(a_mresp), '0);
    chk("t1_sreq_c1", 288'(a_sreq), at(1, r1));
    tick; chk("t1_resp_c2", 288'(a_mresp), '0);
    tick; a_set(1, 32'h1234, 1'b1);
    #1 chk("t1_resp_c3", 288'(a_mresp), rsp(32'h1234));
    tick; a_mreq = '0; a_sresp = '0;
    #1 chk("t1_idle_sreq", 288'(a_sreq), '0);
    chk("t1_idle_resp", 288'(a_mresp), '0);

    // 2: zero-latency on slave2; stale ready afterwards must not reach master
    r2 = rq(32'h8000_0000, 32'h22);
    a_mreq = r2; a_set(2, 32'hAAAA_5555, 1'b1);
    #1 chk("t2_resp", 288'(a_mresp), rsp(32'hAAAA_5555));
    chk("t2_sreq", 288'(a_sreq), at(2, r2));
    tick; a_mreq = '0;
    #1 chk("t2_nobusy", 288'(a_mresp), '0);
    a_sresp = '0;

    // 5: back-to-back slave0 then slave3, stale ready on slave0
    r5a = rq(32'h0000_0100, 32'h5);
    a_mreq = r5a; a_set(0, 32'h11, 1'b1);
    #1 chk("t5_resp0", 288'(a_mresp), rsp(32'h11));
    tick;
    r5b = rq(32'hC000_0004, 32'h6);
    a_mreq = r5b; a_set(0, 32'h99, 1'b1);
    #1 chk("t5_nobubble", 288'(a_sreq), at(3, r5b));
    chk("t5_stale_idle", 288'(a_mresp), '0);
    tick; chk("t5_stale_busy", 288'(a_mresp), '0);
    a_set(3, 32'h33, 1'b1);
    #1 chk("t5_resp3", 288'(a_mresp), rsp(32'h33));
    tick; a_mreq = '0; a_sresp = '0;

    // 4: slave0 silent -> timeout on the 8th BUSY cycle
    r4 = rq(32'h0000_0010, 32'h44);
    a_mreq = r4;
    tick;
    for (int i = 1; i < 8; i++) begin
      chk("t4_wait_resp", 288'(a_mresp), '0);
      chk("t4_wait_sreq", 288'(a_sreq), at(0, r4));
      tick;
    end
    chk("t4_to_resp", 288'(a_mresp), rsp(32'hDEAD_BEEF));
    chk("t4_to_sreq", 288'(a_sreq), '0);
    chk("t4_err_pre", 288'(a_err), '0);
    tick; a_mreq = '0;
    #1 chk("t4_err_set", 288'(a_err), 288'(1));
    a_clr = 1'b1; tick; a_clr = 1'b0;
    #1 chk("t4_err_clr", 288'(a_err), '0);

    // ready on the timeout cycle wins
    r7 = rq(32'h4000_0000, 32'h77);
    a_mreq = r7;
    tick;
    repeat (7) tick;
    a_set(1, 32'h77, 1'b1);
    #1 chk("tw_resp", 288'(a_mresp), rsp(32'h77));
    chk("tw_sreq", 288'(a_sreq), at(1, r7));
    tick; a_mreq = '0; a_sresp = '0;
    #1 chk("tw_noerr", 288'(a_err), '0);

    // 3: decode error on the 3-slave instance
    rb = rq(32'hC000_0000, 32'h0);
    b_mreq = rb;
    #1 chk("t3_sreq_c0", 288'(b_sreq), '0);
    chk("t3_resp_c0", 288'(b_mresp), '0);
    tick; chk("t3_resp_err", 288'(b_mresp), rsp(32'hDEAD_BEEF));
    chk("t3_sreq_err", 288'(b_sreq), '0);
    chk("t3_err_pre", 288'(b_err), '0);
    tick; b_mreq = '0;
    #1 chk("t3_err_set", 288'(b_err), 288'(1));
    // set beats a simultaneous clear
    b_mreq = rb; b_clr = 1'b1;
    tick; chk("t3_err_clr", 288'(b_err), '0);
    tick; b_mreq = '0; b_clr = 1'b0;
    #1 chk("t3_setwins", 288'(b_err), 288'(1));
    b_clr = 1'b1; tick; b_clr = 1'b0;
    #1 chk("t3_err_clr2", 288'(b_err), '0);

    // 6: async reset while BUSY, then a clean transaction
    r6 = rq(32'h4000_0020, 32'h66);
    a_mreq = r6;
    tick; chk("t6_busy_sreq", 288'(a_sreq), at(1, r6));
    rst = 1'b1; a_set(1, 32'h5A, 1'b1);
    #1 chk("t6_rst_sreq", 288'(a_sreq), '0);
    chk("t6_rst_resp", 288'(a_mresp), '0);
    tick; rst = 1'b0; a_sresp = '0;
    #1 chk("t6_post_sreq", 288'(a_sreq), at(1, r6));
    chk("t6_post_resp", 288'(a_mresp), '0);
    tick; a_set(1, 32'h5A, 1'b1);
    #1 chk("t6_done", 288'(a_mresp), rsp(32'h5A));
    tick; a_mreq = '0; a_sresp = '0;
    #1 chk("t6_idle", 288'(a_mresp), '0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
